// File: rtl/uart_cmd_pkg.sv
// Shared types and widths for the UART command assembler.
package uart_cmd_pkg;

    typedef enum logic {IDLE, HIGH} asm_state_t;

    localparam int CMD_W  = 16;
    localparam int BYTE_W = 8;

endpackage

// File: rtl/cmd_timeout_cnt.sv
// Inter-byte timer: counts cycles spent waiting for the low byte and flags the last allowed cycle.
module cmd_timeout_cnt #(
    parameter int LIMIT = 52080
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_limit
);

    localparam int CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

    logic [CW-1:0] r_cnt;

    // Clear wins over enable so a fresh high byte always starts from zero.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_limit = (r_cnt == LAST);

endmodule

// File: rtl/uart_cmd_assembler.sv
// Frames two consecutive UART bytes (high, then low) into a 16-bit command with
// inter-byte timeout and overrun detection.
module uart_cmd_assembler
    import uart_cmd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 52080
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_rx_rdy,
    input  logic [BYTE_W-1:0] i_rx_data,
    output logic              o_clr_rx_rdy,
    output logic [CMD_W-1:0]  o_cmd,
    output logic              o_cmd_rdy,
    input  logic              i_clr_cmd_rdy,
    output logic              o_busy,
    output logic              o_timeout_err,
    output logic              o_overrun
);

    asm_state_t        r_state;
    asm_state_t        w_next;
    logic [BYTE_W-1:0] r_hi_byte;
    logic [CMD_W-1:0]  r_cmd;
    logic              r_cmd_rdy;
    logic              r_timeout_err;
    logic              r_overrun;

    logic w_load_hi;
    logic w_complete;
    logic w_timeout;
    logic w_limit;
    logic w_tmr_clr;
    logic w_tmr_en;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // A byte arriving on the last allowed cycle beats the timeout.
    always_comb begin
        w_next     = r_state;
        w_load_hi  = 1'b0;
        w_complete = 1'b0;
        w_timeout  = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_rx_rdy) begin
                    w_load_hi = 1'b1;
                    w_next    = HIGH;
                end
            end
            HIGH: begin
                if (i_rx_rdy) begin
                    w_complete = 1'b1;
                    w_next     = IDLE;
                end else if (w_limit) begin
                    w_timeout = 1'b1;
                    w_next    = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    assign w_tmr_clr = (r_state == IDLE) || w_complete || w_timeout;
    assign w_tmr_en  = (r_state == HIGH);

    cmd_timeout_cnt #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_tmr (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_clr   (w_tmr_clr),
        .i_en    (w_tmr_en),
        .o_limit (w_limit)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_hi_byte     <= '0;
            r_cmd         <= '0;
            r_cmd_rdy     <= 1'b0;
            r_timeout_err <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            r_timeout_err <= w_timeout;
            r_overrun     <= w_complete && r_cmd_rdy && !i_clr_cmd_rdy;
            if (w_load_hi) begin
                r_hi_byte <= i_rx_data;
            end
            // Completion outranks the consumer's acknowledge.
            if (w_complete) begin
                r_cmd     <= {r_hi_byte, i_rx_data};
                r_cmd_rdy <= 1'b1;
            end else if (i_clr_cmd_rdy) begin
                r_cmd_rdy <= 1'b0;
            end
        end
    end

    // Every rx_rdy cycle is consumed in either state.
    assign o_clr_rx_rdy  = i_rx_rdy && !i_rst;
    assign o_cmd         = r_cmd;
    assign o_cmd_rdy     = r_cmd_rdy;
    assign o_busy        = (r_state == HIGH);
    assign o_timeout_err = r_timeout_err;
    assign o_overrun     = r_overrun;

endmodule

// File: tb/tb_uart_cmd_assembler.sv
// Self-checking bench for uart_cmd_assembler: vector table, directed corner cases, random vs model.
module tb_uart_cmd_assembler;

    localparam int TO = 50;

    logic        clk = 1'b0;
    logic        rst, rx_rdy, clr_cmd_rdy;
    logic [7:0]  rx_data;
    logic        clr_rx_rdy, cmd_rdy, busy, timeout_err, overrun;
    logic [15:0] cmd;

    int checks   = 0;
    int failures = 0;
    int n_clr    = 0;
    int n_to     = 0;

    // Reference model: pending high byte and its age in clock edges.
    bit        m_pend;
    bit [7:0]  m_hi;
    int        m_age;
    bit [15:0] m_cmd;
    bit        m_rdy, m_to, m_ov;

    typedef struct {
        logic        rst, rdy;
        logic [7:0]  d;
        logic        clr;
        logic [15:0] e_cmd;
        logic        e_rdy, e_busy, e_to, e_ov;
    } vec_t;

    vec_t tbl[$];

    uart_cmd_assembler #(.TIMEOUT_CYCLES(TO)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_rx_rdy      (rx_rdy),
        .i_rx_data     (rx_data),
        .o_clr_rx_rdy  (clr_rx_rdy),
        .o_cmd         (cmd),
        .o_cmd_rdy     (cmd_rdy),
        .i_clr_cmd_rdy (clr_cmd_rdy),
        .o_busy        (busy),
        .o_timeout_err (timeout_err),
        .o_overrun     (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit rdy, input bit [7:0] d, input bit clr);
        bit done;
        done = 1'b0;
        if (r) begin
            m_pend = 0; m_hi = 0; m_age = 0; m_cmd = 0; m_rdy = 0; m_to = 0; m_ov = 0;
        end else begin
            m_to = 0;
            m_ov = 0;
            if (rdy) begin
                if (!m_pend) begin
                    m_pend = 1; m_hi = d; m_age = 0;
                end else begin
                    done   = 1'b1;
                    m_ov   = m_rdy && !clr;
                    m_cmd  = {m_hi, d};
                    m_rdy  = 1;
                    m_pend = 0;
                end
            end else if (m_pend) begin
                m_age++;
                if (m_age == TO) begin
                    m_pend = 0;
                    m_to   = 1;
                end
            end
            if (!done && clr) m_rdy = 0;
        end
    endtask

    // One clock: drive at posedge+1, check combinational consume, clock, then compare to model.
    task automatic cyc(input logic r, input logic rdy, input logic [7:0] d, input logic clr);
        rst = r; rx_rdy = rdy; rx_data = d; clr_cmd_rdy = clr;
        #1;
        if (clr_rx_rdy === 1'b1) n_clr++;
        chk("clr_rx_rdy", {15'd0, clr_rx_rdy}, {15'd0, rdy & ~r});
        @(posedge clk);
        model_step(r, rdy, d, clr);
        #1;
        if (timeout_err === 1'b1) n_to++;
        chk("m_cmd", cmd, m_cmd);
        chk("m_cmd_rdy", {15'd0, cmd_rdy}, {15'd0, m_rdy});
        chk("m_busy", {15'd0, busy}, {15'd0, m_pend});
        chk("m_timeout_err", {15'd0, timeout_err}, {15'd0, m_to});
        chk("m_overrun", {15'd0, overrun}, {15'd0, m_ov});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 8'h00, 0);
    endtask

    initial begin
        rst = 1; rx_rdy = 0; rx_data = 0; clr_cmd_rdy = 0;
        @(posedge clk); #1;
        cyc(1, 0, 8'h00, 0);
        chk("reset_cmd", cmd, 16'h0000);
        chk("reset_flags", {11'd0, cmd_rdy, busy, timeout_err, overrun, clr_rx_rdy}, 16'h0000);

        // rst rdy d clr | cmd rdy busy to ov
        tbl.push_back('{0, 1, 8'hA5, 0, 16'h0000, 0, 1, 0, 0});
        tbl.push_back('{0, 0, 8'h00, 0, 16'h0000, 0, 1, 0, 0});
        tbl.push_back('{0, 1, 8'h3C, 0, 16'hA53C, 1, 0, 0, 0});
        tbl.push_back('{0, 0, 8'h00, 1, 16'hA53C, 0, 0, 0, 0});
        tbl.push_back('{0, 1, 8'h01, 0, 16'hA53C, 0, 1, 0, 0});
        tbl.push_back('{0, 1, 8'h02, 0, 16'h0102, 1, 0, 0, 0});
        tbl.push_back('{0, 1, 8'h03, 0, 16'h0102, 1, 1, 0, 0});
        tbl.push_back('{0, 1, 8'h04, 0, 16'h0304, 1, 0, 0, 1});
        tbl.push_back('{0, 0, 8'h00, 0, 16'h0304, 1, 0, 0, 0});
        tbl.push_back('{0, 1, 8'h05, 0, 16'h0304, 1, 1, 0, 0});
        tbl.push_back('{0, 1, 8'h06, 1, 16'h0506, 1, 0, 0, 0});
        tbl.push_back('{0, 0, 8'h00, 1, 16'h0506, 0, 0, 0, 0});
        foreach (tbl[i]) begin
            cyc(tbl[i].rst, tbl[i].rdy, tbl[i].d, tbl[i].clr);
            chk("tbl_cmd", cmd, tbl[i].e_cmd);
            chk("tbl_flags", {12'd0, cmd_rdy, busy, timeout_err, overrun},
                {12'd0, tbl[i].e_rdy, tbl[i].e_busy, tbl[i].e_to, tbl[i].e_ov});
        end

        // Two bytes well apart but inside the window: exactly two consume strobes.
        n_clr = 0;
        cyc(0, 1, 8'hA5, 0);
        idle(40);
        cyc(0, 1, 8'h3C, 0);
        chk("t1_cmd", cmd, 16'hA53C);
        chk("t1_cmd_rdy", {15'd0, cmd_rdy}, 16'd1);
        idle(3);
        chk("t1_clr_pulses", n_clr[15:0], 16'd2);
        cyc(0, 0, 8'h00, 1);

        // Lone high byte times out exactly TO edges after accept.
        n_to = 0;
        cyc(0, 1, 8'h11, 0);
        idle(TO - 1);
        chk("t2_busy_before", {15'd0, busy}, 16'd1);
        chk("t2_no_early_to", n_to[15:0], 16'd0);
        cyc(0, 0, 8'h00, 0);
        chk("t2_timeout", {15'd0, timeout_err}, 16'd1);
        chk("t2_busy_after", {15'd0, busy}, 16'd0);
        cyc(0, 0, 8'h00, 0);
        chk("t2_pulse_len", {15'd0, timeout_err}, 16'd0);
        cyc(0, 1, 8'h22, 0);
        cyc(0, 1, 8'h33, 0);
        chk("t2_cmd", cmd, 16'h2233);
        cyc(0, 0, 8'h00, 1);

        // Low byte on the last allowed cycle wins over the timeout.
        n_to = 0;
        cyc(0, 1, 8'h55, 0);
        idle(TO - 1);
        cyc(0, 1, 8'hAA, 0);
        chk("t5_cmd", cmd, 16'h55AA);
        chk("t5_to", {15'd0, timeout_err}, 16'd0);
        idle(2);
        chk("t5_no_to_pulses", n_to[15:0], 16'd0);

        // Reset mid-frame drops the high byte silently.
        cyc(0, 1, 8'h77, 0);
        chk("t6_busy", {15'd0, busy}, 16'd1);
        cyc(1, 0, 8'h00, 0);
        chk("t6_rst_cmd", cmd, 16'h0000);
        chk("t6_rst_flags", {12'd0, cmd_rdy, busy, timeout_err, overrun}, 16'h0000);
        cyc(0, 1, 8'hFF, 0);
        cyc(0, 1, 8'h00, 0);
        chk("t6_cmd", cmd, 16'hFF00);

        for (int i = 0; i < 4000; i++) begin
            cyc(($urandom_range(0, 499) == 0), ($urandom_range(0, 29) == 0),
                8'($urandom), ($urandom_range(0, 3) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
